// File: rtl/issue_select_ctrl.sv
// rtl/issue_select_ctrl.sv - age-ordered wakeup/select scheduler for the out-of-order issue queue
// Optional feature macro: ISSUE_WAKEUP_BYPASS_EN (same-cycle wakeup counts as ready for select)
module issue_select_ctrl #(
  parameter int QUEUE_SIZE = 8,
  parameter int TAG_W      = 6,
  parameter int IDX_W      = $clog2(QUEUE_SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_valid,
  output logic             disp_ready,
  output logic [IDX_W-1:0] disp_slot,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic             disp_src1_rdy,
  input  logic             disp_src2_rdy,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic             ex_stall,
  input  logic             flush,
  output logic             issue_valid,
  output logic [IDX_W-1:0] issue_slot,
  output logic [IDX_W:0]   occupancy
);

  logic [QUEUE_SIZE-1:0] valid_q;
  logic [QUEUE_SIZE-1:0] rdy1_q;
  logic [QUEUE_SIZE-1:0] rdy2_q;
  logic [TAG_W-1:0]      src1_tag_q [QUEUE_SIZE];
  logic [TAG_W-1:0]      src2_tag_q [QUEUE_SIZE];
  logic [IDX_W-1:0]      rank_q     [QUEUE_SIZE];

  logic [QUEUE_SIZE-1:0] wake1;
  logic [QUEUE_SIZE-1:0] wake2;
  logic [QUEUE_SIZE-1:0] cand;
  logic                  win_found;
  logic [IDX_W-1:0]      win_slot;
  logic [IDX_W-1:0]      win_rank;
  logic                  do_issue;
  logic                  do_disp;
  logic [IDX_W-1:0]      new_rank;
  logic                  new_rdy1;
  logic                  new_rdy2;

  // Lowest-index free slot; scanning downward leaves the lowest match last.
  always_comb begin
    disp_slot = '0;
    for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
      if (!valid_q[i]) disp_slot = IDX_W'(i);
    end
    disp_ready = (occupancy != (IDX_W + 1)'(QUEUE_SIZE));
  end

  // Tag match against the broadcast, and the select candidate set.
  always_comb begin
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      wake1[i] = wb_valid && (src1_tag_q[i] == wb_tag);
      wake2[i] = wb_valid && (src2_tag_q[i] == wb_tag);
`ifdef ISSUE_WAKEUP_BYPASS_EN
      cand[i]  = valid_q[i] && (rdy1_q[i] || wake1[i]) && (rdy2_q[i] || wake2[i]);
`else
      cand[i]  = valid_q[i] && rdy1_q[i] && rdy2_q[i];
`endif
    end
  end

  // Oldest-ready select: ranks of valid entries are unique, so the minimum is unambiguous.
  always_comb begin
    win_found = 1'b0;
    win_slot  = '0;
    win_rank  = '0;
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      if (cand[i] && (!win_found || rank_q[i] < win_rank)) begin
        win_found = 1'b1;
        win_slot  = IDX_W'(i);
        win_rank  = rank_q[i];
      end
    end
    do_issue = win_found && !ex_stall && !flush;
    do_disp  = disp_valid && disp_ready && !flush;
    new_rank = occupancy[IDX_W-1:0] - (do_issue ? IDX_W'(1) : IDX_W'(0));
    new_rdy1 = disp_src1_rdy || (wb_valid && (wb_tag == disp_src1_tag));
    new_rdy2 = disp_src2_rdy || (wb_valid && (wb_tag == disp_src2_tag));
  end

  // Per-entry state: wakeup, issue removal with rank compaction, dispatch write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        src1_tag_q[i] <= '0;
        src2_tag_q[i] <= '0;
        rank_q[i]     <= '0;
      end
    end else if (flush) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        rank_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < QUEUE_SIZE; i++) begin
        if (valid_q[i]) begin
          if (wake1[i]) rdy1_q[i] <= 1'b1;
          if (wake2[i]) rdy2_q[i] <= 1'b1;
          if (do_issue && win_slot == IDX_W'(i)) begin
            valid_q[i] <= 1'b0;
          end else if (do_issue && rank_q[i] > win_rank) begin
            rank_q[i] <= rank_q[i] - IDX_W'(1);
          end
        end else if (do_disp && disp_slot == IDX_W'(i)) begin
          valid_q[i]    <= 1'b1;
          src1_tag_q[i] <= disp_src1_tag;
          src2_tag_q[i] <= disp_src2_tag;
          rdy1_q[i]     <= new_rdy1;
          rdy2_q[i]     <= new_rdy2;
          rank_q[i]     <= new_rank;
        end
      end
    end
  end

  // Registered issue report and entry count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid <= 1'b0;
      issue_slot  <= '0;
      occupancy   <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
      occupancy   <= '0;
    end else begin
      issue_valid <= do_issue;
      if (do_issue) issue_slot <= win_slot;
      case ({do_disp, do_issue})
        2'b10:   occupancy <= occupancy + (IDX_W + 1)'(1);
        2'b01:   occupancy <= occupancy - (IDX_W + 1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: doc/issue_select_ctrl.md
# issue_select_ctrl

Scheduler for the out-of-order instruction queue. It tracks slot occupancy, source-operand readiness and relative age for each queue entry, and allocates a free slot to each dispatched instruction from register renaming. Every cycle the execute stage is not stalled, it picks the oldest ready entry and issues it. It holds no instruction payload: the queue RAM is written at `disp_slot` and read at `issue_slot`.

## Interface
- `QUEUE_SIZE`, 8: number of queue entries; power of two, 2..32.
- `TAG_W`, 6: physical-register tag width.
- `IDX_W`, `$clog2(QUEUE_SIZE)`: slot index width (derived; do not override).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `disp_valid`  in  1  rename stage presents an instruction.
- `disp_ready`  out  1  a free slot exists; dispatch accepted when `disp_valid & disp_ready`.
- `disp_slot`  out  IDX_W  slot the accepted instruction is written into (queue RAM write address).
- `disp_src1_tag`, `disp_src2_tag`  in  TAG_W  physical source tags.
- `disp_src1_rdy`, `disp_src2_rdy`  in  1  source already available at rename.
- `wb_valid`  in  1  wakeup broadcast valid.
- `wb_tag`  in  TAG_W  tag of the result being produced.
- `ex_stall`  in  1  execute stage cannot accept an instruction this cycle.
- `flush`  in  1  discard all queued entries (branch mispredict).
- `issue_valid`  out  1  registered; an entry was issued at the last edge.
- `issue_slot`  out  IDX_W  registered; slot index of the issued entry.
- `occupancy`  out  IDX_W+1  registered count of valid entries.

## Operation
- Per-entry state:
  - `valid`
  - `src1_tag` / `src2_tag`
  - `rdy1` / `rdy2`
  - `rank` (IDX_W bits; 0 = oldest)
- Valid-entry ranks are always unique and contiguous, 0..occupancy-1.
- **Allocation:** `disp_slot` is the lowest-index invalid slot, computed combinationally from current state. `disp_ready = (occupancy != QUEUE_SIZE)`; it does not look ahead to a same-cycle issue.
- **Dispatch write:**
  - The new entry gets `rank = occupancy`, or `occupancy - 1` if an issue also happens at that edge.
  - `rdyN = disp_srcN_rdy | (wb_valid & wb_tag == disp_srcN_tag)`.
- **Wakeup:** each valid entry whose `srcN_tag == wb_tag` while `wb_valid` is high sets `rdyN` at the edge. Both sources may match the same tag.
- **Select:** the candidate set is valid entries with `rdy1 & rdy2` (see Configuration). The entry with the minimum rank wins.
- **Issue:** when a winner exists and `ex_stall == 0`:
  - At the edge, the winner's `valid` is cleared.
  - Every entry with a rank above the winner's decrements its rank.
  - `issue_valid <= 1` and `issue_slot <= winner`.
  - Otherwise `issue_valid <= 0` and `issue_slot` holds its value.
- `occupancy` changes by +1 for a dispatch and −1 for an issue; both in the same edge leave it unchanged.
- **Flush:** has priority over everything.
  - At the edge, all `valid`, `rdy` and `rank` bits clear, `occupancy <= 0` and `issue_valid <= 0`.
  - A dispatch presented in the flush cycle is dropped, even though `disp_ready` may be high.

## Timing
- **Reset values:**
  - `issue_valid = 0`, `issue_slot = 0`, `occupancy = 0`.
  - `disp_ready = 1` and `disp_slot = 0` (combinational from the reset state).
  - All entries invalid.
- **Dispatch-to-issue latency:** an entry dispatched at edge N with both sources ready may be selected in cycle N+1; `issue_valid` is high after edge N+1. There is no same-cycle dispatch-to-issue bypass.
- **Wakeup-to-issue latency:** a wakeup at edge N makes the entry a candidate in cycle N+1 (baseline).
- **Full:** a slot freed by an issue at edge N is allocatable in cycle N+1.
- **`ex_stall`:** entries are held with no loss. Wakeups and dispatches continue during a stall.
- **`rst_n` asserted mid-operation:** all state clears immediately (asynchronous); in-flight wakeups are lost.

## Configuration
- Macro: `ISSUE_WAKEUP_BYPASS_EN`.
- **Defined:** a source matching `wb_tag` in the current cycle counts as ready for select in that same cycle. Wakeup-to-issue is then 0 cycles: wakeup in cycle N gives `issue_valid` after edge N. The dispatch path is unchanged.
- **Undefined:** select uses only the stored `rdy` bits (1-cycle wakeup-to-issue).

## Test plan
- **Reset then single dispatch:**
  - Stimulus: after reset, dispatch one entry with both srcs ready.
  - Response: `disp_slot=0`; the next cycle gives `issue_valid=1`, `issue_slot=0`, `occupancy` 1→0.
- **Age ordering:**
  - Stimulus: dispatch A (slot 0, src1 tag 5 not ready), then B (slot 1) and C (slot 2), both ready; then `wb_tag=5`.
  - Response: issue order is B, C, A, one per cycle.
- **Full queue:**
  - Stimulus: dispatch 8 not-ready entries.
  - Response: `disp_ready=0` and `occupancy=8`.
  - Then wake up slot 3: it issues, and the next allocation returns `disp_slot=3`.
- **Stall:**
  - Stimulus: hold `ex_stall=1` for 3 cycles with 2 ready entries.
  - Response: `issue_valid=0` and `occupancy` unchanged.
  - On release, the two entries issue back-to-back in rank order.
- **Dispatch-time wakeup and flush:**
  - Stimulus: dispatch with `src1_tag=9` while `wb_tag=9`; the entry issues next cycle.
  - Then, with 4 entries queued plus a concurrent dispatch, assert `flush`.
  - Response: after the edge `occupancy=0`, `issue_valid=0`, and nothing issues afterwards.
- **Bypass (with `ISSUE_WAKEUP_BYPASS_EN`):**
  - Stimulus: an entry waiting on tag 12; assert `wb_tag=12`.
  - Response: `issue_valid=1` after that same edge.
